// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and shared memory port of the two-requester arbiter.
// slave is the arbiter's view of the bundle; master is the surrounding CPU/memory view.
interface mem_port_arbiter_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iaddr_ok;
  logic        idata_ok;
  logic [31:0] irdata;
  logic        dreq;
  logic        dwr;
  logic [3:0]  dwstrb;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        daddr_ok;
  logic        ddata_ok;
  logic [31:0] drdata;
  logic        mreq;
  logic        mwr;
  logic [3:0]  mwstrb;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic        maddr_ok;
  logic        mdata_ok;
  logic [31:0] mrdata;

  modport slave (
    input  ireq, iaddr, dreq, dwr, dwstrb, daddr, dwdata, maddr_ok, mdata_ok, mrdata,
    output iaddr_ok, idata_ok, irdata, daddr_ok, ddata_ok, drdata,
           mreq, mwr, mwstrb, maddr, mwdata
  );

  modport master (
    output ireq, iaddr, dreq, dwr, dwstrb, daddr, dwdata, maddr_ok, mdata_ok, mrdata,
    input  iaddr_ok, idata_ok, irdata, daddr_ok, ddata_ok, drdata,
           mreq, mwr, mwstrb, maddr, mwdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// in flight; data side has priority but fetch is forced in after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned   CW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          req_s;
  logic          grant_d_s;
  logic          hs_s;
  logic          resp_s;

  // Request path: pick a winner, forward its attributes and pulse its accept
  always_comb begin
    grant_d_s = bus.dreq && !(bus.ireq && (starve_q == SMAX));
    req_s     = !reset && (state_q == IDLE) && (bus.ireq || bus.dreq);
    hs_s      = req_s && bus.maddr_ok;
    bus.mreq  = req_s;
    if (req_s && grant_d_s) begin
      bus.mwr    = bus.dwr;
      bus.mwstrb = bus.dwstrb;
      bus.maddr  = bus.daddr;
      bus.mwdata = bus.dwdata;
    end else if (req_s) begin
      bus.mwr    = 1'b0;
      bus.mwstrb = 4'b0000;
      bus.maddr  = bus.iaddr;
      bus.mwdata = 32'h0000_0000;
    end else begin
      bus.mwr    = 1'b0;
      bus.mwstrb = 4'b0000;
      bus.maddr  = 32'h0000_0000;
      bus.mwdata = 32'h0000_0000;
    end
    bus.daddr_ok = hs_s && grant_d_s;
    bus.iaddr_ok = hs_s && !grant_d_s;
  end

  // Response path: route memory data to whoever owns the outstanding access
  always_comb begin
    resp_s       = !reset && (state_q == WAIT) && bus.mdata_ok;
    bus.idata_ok = resp_s && (owner_q == OWN_I);
    bus.ddata_ok = resp_s && (owner_q == OWN_D);
    if (bus.idata_ok) begin
      bus.irdata = bus.mrdata;
    end else begin
      bus.irdata = 32'h0000_0000;
    end
    if (bus.ddata_ok) begin
      bus.drdata = bus.mrdata;
    end else begin
      bus.drdata = 32'h0000_0000;
    end
  end

  // Next state: owner capture on accept, starvation counting, release on response
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if (reset) begin
      state_d  = IDLE;
      owner_d  = OWN_I;
      starve_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_s) begin
            state_d = WAIT;
            if (grant_d_s) begin
              owner_d = OWN_D;
              // only data wins that make fetch wait count toward starvation
              if (bus.ireq && (starve_q != SMAX)) begin
                starve_d = starve_q + CW'(1);
              end else begin
                starve_d = starve_q;
              end
            end else begin
              owner_d  = OWN_I;
              starve_d = '0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (bus.mdata_ok) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    owner_q  <= owner_d;
    starve_q <= starve_d;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (pending queue + count of data wins over fetch).
module tb_mem_port_arbiter;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // model state: owners of accepted-but-unanswered accesses, data wins while fetch waited
  bit          pend_q[$];
  int unsigned dwins = 0;
  byte         glog[$];

  logic        e_mreq, e_iaok, e_daok, e_idok, e_ddok, e_mwr, e_tod;
  logic [3:0]  e_strb;
  logic [31:0] e_addr, e_wdata, e_ir, e_dr;
  bit          u_tod;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model update on the active edge, from inputs held stable since the previous edge
  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
      dwins = 0;
    end else if (pend_q.size() == 0) begin
      if ((bus.ireq || bus.dreq) && bus.maddr_ok) begin
        u_tod = bus.dreq && (!bus.ireq || dwins < SMAX);
        pend_q.push_back(u_tod);
        if (!u_tod) dwins = 0;
        else if (bus.ireq && dwins < SMAX) dwins++;
      end
    end else if (bus.mdata_ok) begin
      void'(pend_q.pop_front());
    end
  end

  // per-cycle compare against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      e_mreq = 1'b0; e_iaok = 1'b0; e_daok = 1'b0; e_idok = 1'b0; e_ddok = 1'b0;
      e_mwr = 1'b0; e_strb = 4'b0000; e_addr = 32'h0; e_wdata = 32'h0; e_ir = 32'h0; e_dr = 32'h0;
      e_tod = 1'b0;
      if (!reset) begin
        if (pend_q.size() == 0) begin
          if (bus.ireq || bus.dreq) begin
            e_mreq = 1'b1;
            e_tod  = bus.dreq && (!bus.ireq || dwins < SMAX);
            if (e_tod) begin
              e_addr = bus.daddr; e_mwr = bus.dwr; e_strb = bus.dwstrb; e_wdata = bus.dwdata;
              e_daok = bus.maddr_ok;
            end else begin
              e_addr = bus.iaddr;
              e_iaok = bus.maddr_ok;
            end
          end
        end else if (bus.mdata_ok) begin
          if (pend_q[0]) begin e_ddok = 1'b1; e_dr = bus.mrdata; end
          else begin e_idok = 1'b1; e_ir = bus.mrdata; end
        end
      end
      chk("mreq",     32'(bus.mreq),     32'(e_mreq));
      chk("iaddr_ok", 32'(bus.iaddr_ok), 32'(e_iaok));
      chk("daddr_ok", 32'(bus.daddr_ok), 32'(e_daok));
      chk("idata_ok", 32'(bus.idata_ok), 32'(e_idok));
      chk("ddata_ok", 32'(bus.ddata_ok), 32'(e_ddok));
      chk("irdata",   bus.irdata,        e_ir);
      chk("drdata",   bus.drdata,        e_dr);
      chk("mwr",      32'(bus.mwr),      32'(e_mwr));
      chk("mwstrb",   32'(bus.mwstrb),   32'(e_strb));
      chk("maddr",    bus.maddr,         e_addr);
      chk("mwdata",   bus.mwdata,        e_wdata);
      if (bus.iaddr_ok) glog.push_back(8'h49);
      if (bus.daddr_ok) glog.push_back(8'h44);
    end
  end

  task automatic clr();
    bus.ireq = 1'b0; bus.iaddr = 32'h0; bus.dreq = 1'b0; bus.dwr = 1'b0; bus.dwstrb = 4'h0;
    bus.daddr = 32'h0; bus.dwdata = 32'h0; bus.maddr_ok = 1'b0; bus.mdata_ok = 1'b0;
    bus.mrdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    string exp_seq;
    byte   c;
    reset = 1'b1;
    clr();
    bus.ireq = 1'b1; bus.dreq = 1'b1; bus.maddr_ok = 1'b1; bus.mdata_ok = 1'b1;
    step();
    chk_en = 1'b1;
    look();
    chk("rst_mreq", 32'(bus.mreq), 32'd0);
    chk("rst_iaok", 32'(bus.iaddr_ok), 32'd0);
    chk("rst_daok", 32'(bus.daddr_ok), 32'd0);
    step();
    reset = 1'b0;
    clr();

    // single load
    bus.dreq = 1'b1; bus.daddr = 32'h0000_1000; bus.maddr_ok = 1'b1;
    look();
    chk("ld_daok", 32'(bus.daddr_ok), 32'd1);
    chk("ld_maddr", bus.maddr, 32'h0000_1000);
    chk("ld_iaok", 32'(bus.iaddr_ok), 32'd0);
    step(); clr();
    look();
    chk("ld_wait_mreq", 32'(bus.mreq), 32'd0);
    step();
    bus.mdata_ok = 1'b1; bus.mrdata = 32'hDEAD_BEEF;
    look();
    chk("ld_ddok", 32'(bus.ddata_ok), 32'd1);
    chk("ld_drdata", bus.drdata, 32'hDEAD_BEEF);
    chk("ld_idok", 32'(bus.idata_ok), 32'd0);
    step(); clr();

    // accept withheld for three cycles
    bus.dreq = 1'b1; bus.daddr = 32'h0000_0044;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("hold_mreq", 32'(bus.mreq), 32'd1);
      chk("hold_daok", 32'(bus.daddr_ok), 32'd0);
      step();
    end
    bus.maddr_ok = 1'b1;
    look();
    chk("hold_daok_final", 32'(bus.daddr_ok), 32'd1);
    step(); clr();
    bus.mdata_ok = 1'b1;
    look();
    chk("hold_ddok", 32'(bus.ddata_ok), 32'd1);
    step(); clr();

    // simultaneous requests: data first, fetch once data completes
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0100; bus.dreq = 1'b1; bus.daddr = 32'h0000_0200;
    bus.maddr_ok = 1'b1;
    look();
    chk("sim_daok", 32'(bus.daddr_ok), 32'd1);
    chk("sim_maddr", bus.maddr, 32'h0000_0200);
    chk("sim_iaok", 32'(bus.iaddr_ok), 32'd0);
    step();
    bus.dreq = 1'b0; bus.maddr_ok = 1'b0; bus.mdata_ok = 1'b1;
    look();
    chk("sim_ddok", 32'(bus.ddata_ok), 32'd1);
    step();
    bus.maddr_ok = 1'b1; bus.mdata_ok = 1'b0;
    look();
    chk("sim_iaok2", 32'(bus.iaddr_ok), 32'd1);
    chk("sim_maddr2", bus.maddr, 32'h0000_0100);
    step(); clr();
    bus.mdata_ok = 1'b1; bus.mrdata = 32'h0BAD_C0DE;
    look();
    chk("sim_idok", 32'(bus.idata_ok), 32'd1);
    chk("sim_irdata", bus.irdata, 32'h0BAD_C0DE);
    step(); clr();

    // starvation: fetch forced in after four data wins, then data wins again
    glog.delete();
    for (int t = 0; t < 6; t++) begin
      bus.ireq = 1'b1; bus.iaddr = 32'h0000_0400; bus.dreq = 1'b1; bus.daddr = 32'h0000_0500;
      bus.maddr_ok = 1'b1; bus.mdata_ok = 1'b0;
      step();
      bus.maddr_ok = 1'b0; bus.mdata_ok = 1'b1; bus.mrdata = 32'(t);
      step();
    end
    clr();
    exp_seq = "DDDDID";
    chk("starve_len", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) begin
        c = exp_seq[i];
        chk("starve_seq", 32'(glog[i]), 32'(c));
      end
    end

    // store
    bus.dreq = 1'b1; bus.dwr = 1'b1; bus.dwstrb = 4'b0011; bus.dwdata = 32'h1234_5678;
    bus.daddr = 32'h0000_2000; bus.maddr_ok = 1'b1;
    look();
    chk("st_mwr", 32'(bus.mwr), 32'd1);
    chk("st_mwstrb", 32'(bus.mwstrb), 32'd3);
    chk("st_mwdata", bus.mwdata, 32'h1234_5678);
    chk("st_daok", 32'(bus.daddr_ok), 32'd1);
    step(); clr();
    bus.mdata_ok = 1'b1; bus.mrdata = 32'hCAFE_F00D;
    look();
    chk("st_ddok", 32'(bus.ddata_ok), 32'd1);
    chk("st_drdata", bus.drdata, 32'hCAFE_F00D);
    step(); clr();

    // reset abandons an outstanding fetch
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0300; bus.maddr_ok = 1'b1;
    look();
    chk("ra_iaok", 32'(bus.iaddr_ok), 32'd1);
    step(); clr();
    reset = 1'b1;
    look();
    chk("ra_rst_mreq", 32'(bus.mreq), 32'd0);
    step();
    reset = 1'b0; bus.mdata_ok = 1'b1; bus.ireq = 1'b1;
    look();
    chk("ra_idok", 32'(bus.idata_ok), 32'd0);
    chk("ra_ddok", 32'(bus.ddata_ok), 32'd0);
    chk("ra_mreq", 32'(bus.mreq), 32'd1);
    step(); clr();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      bus.ireq     = ($urandom_range(0, 3) != 0);
      bus.iaddr    = $urandom;
      bus.dreq     = ($urandom_range(0, 3) != 0);
      bus.dwr      = 1'($urandom);
      bus.dwstrb   = 4'($urandom);
      bus.daddr    = $urandom;
      bus.dwdata   = $urandom;
      bus.maddr_ok = ($urandom_range(0, 2) != 0);
      bus.mdata_ok = ($urandom_range(0, 2) == 0);
      bus.mrdata   = $urandom;
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
